collision_monitor: RTL
======================

COLLISION_MONITOR -- requirements
Module: collision_monitor

Interface
REQ-001 SHALL have parameter N_BULLETS, default 3, number of bullet sprite inputs.
REQ-002 SHALL have parameter HP_MAX, default 20, starting hit points.
REQ-003 SHALL have parameter DAMAGE, default 4, HP removed per damaging frame.
REQ-004 SHALL have parameter INV_FRAMES, default 30, invulnerability length in frames.
REQ-005 SHALL have port clk  in  1  pixel clock; the block's only clock.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port state  in  4  game state; battle phase = 1.
REQ-008 SHALL have ports x, y  in  10 each  current scan pixel coordinates.
REQ-009 SHALL have port heartSpriteOn  in  1  player heart covers current pixel.
REQ-010 SHALL have port bulletSpriteOn  in  N_BULLETS  per-bullet pixel coverage.
REQ-011 SHALL have port collision  out  N_BULLETS  per-bullet hit pulse, fed back to the bullet sprites.
REQ-012 SHALL have port hp  out  7  current hit points, unsigned.
REQ-013 SHALL have port hitPulse  out  1  one-cycle pulse when damage is applied.
REQ-014 SHALL have port gameOver  out  1  level, high once hp reaches 0.
REQ-015 SHALL have port heartVisible  out  1  heart draw enable.

Function
REQ-016 SHALL define end-of-frame (EOF) as x==639 and y==479.
REQ-017 SHALL set overlap flag k on any cycle where state==1, heartSpriteOn and bulletSpriteOn[k] are all high.
REQ-018 SHALL leave flags unchanged when state!=1.
REQ-019 SHALL evaluate the flags on the EOF cycle, then clear all flags on the next cycle.
REQ-020 SHALL include a pixel overlapping on the EOF cycle itself in that cycle's evaluation.
REQ-021 SHALL implement FSM states IDLE, ACTIVE, INVULN and DEAD.
REQ-022 IDLE SHALL go to ACTIVE when state==1.
REQ-023 ACTIVE SHALL go to IDLE when state!=1.
REQ-024 ACTIVE on EOF with any flag set SHALL pulse collision[k] for each set flag for exactly the cycle after EOF.
REQ-025 The ACTIVE damaging EOF SHALL also pulse hitPulse on that same cycle.
REQ-026 The ACTIVE damaging EOF SHALL subtract DAMAGE from hp, saturating at 0 (no wrap).
REQ-027 After a damaging EOF, ACTIVE SHALL go to DEAD if the new hp is 0, else to INVULN with the frame counter loaded to INV_FRAMES.
REQ-028 INVULN SHALL ignore overlaps and assert no collision or hitPulse.
REQ-029 INVULN SHALL decrement the frame counter on each EOF and go to ACTIVE on the EOF where the counter reaches 0.
REQ-030 INVULN SHALL keep counting while state!=1.
REQ-031 DEAD SHALL be terminal until reset; gameOver=1 and hp=0 in DEAD.
REQ-032 Multiple simultaneous bullet overlaps in one frame SHALL apply DAMAGE once only.
REQ-033 The frame counter SHALL be wide enough for INV_FRAMES; hp arithmetic SHALL be 7-bit unsigned.
REQ-034 heartVisible SHALL be 1 in all states unless REQ-042 applies.

Reset
REQ-035 While rst_n=0, the block SHALL set hp=HP_MAX, collision=0, hitPulse=0, gameOver=0, heartVisible=1.
REQ-036 While rst_n=0, the block SHALL set FSM=IDLE, all flags=0 and counter=0.
REQ-037 Reset asserted mid-frame or mid-INVULN SHALL abort immediately, with no pending pulse after release.

Configuration
REQ-038 Macro HIT_FLASH_EN SHALL select the blink feature.
REQ-039 When HIT_FLASH_EN is defined, heartVisible SHALL toggle every 4 frames during INVULN, starting low on the first INVULN frame.
REQ-040 When HIT_FLASH_EN is defined, heartVisible SHALL return to 1 on leaving INVULN.
REQ-041 When HIT_FLASH_EN is undefined, heartVisible SHALL be constant 1 and no blink logic SHALL exist.
REQ-042 The blink behaviour SHALL be active only when HIT_FLASH_EN is defined.

Structure
REQ-043 A shared package undertale_pkg SHALL hold the state encodings (battle=1), screen extents (640x480) and EOF coordinates.
REQ-044 The package SHALL also hold the FSM state enum typedef.
REQ-045 One sub-module, hp_counter, SHALL own the saturating hp register, the DAMAGE subtract and the zero flag.

Verification
REQ-046 Bench: state=1, heart and bullet[0] overlap 1 pixel in frame 1 -> cycle after EOF: collision=3'b001, hitPulse=1, hp=16, INVULN.
REQ-047 Bench: overlaps in each of the next 30 frames -> hp stays 16, no pulses; overlap in frame 32 -> hp=12.
REQ-048 Bench: bullets 0 and 2 overlap in the same frame -> collision=3'b101, hp drops by 4 once.
REQ-049 Bench: five damaging frames spaced >30 frames apart -> hp=0, gameOver=1, DEAD; further overlaps change nothing.
REQ-050 Bench: state=0 with overlaps present -> no flags, hp=20; rst_n pulsed mid-INVULN -> hp=20, IDLE, no stale collision.
REQ-051 Bench: HIT_FLASH_EN defined -> heartVisible pattern 0000 1111 0000... across INVULN frames, then 1 in ACTIVE.

Source files
------------

// File: rtl/undertale_pkg.sv
// Shared game constants: state encodings, screen geometry, end-of-frame coordinates, monitor FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package undertale_pkg;

  // Game state encoding driven by the top-level game controller
  localparam logic [3:0] ST_BATTLE = 4'd1;

  // Visible screen extents
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Last visible pixel of a frame; seeing it marks end-of-frame
  localparam logic [9:0] EOF_X = 10'(SCREEN_W - 1);
  localparam logic [9:0] EOF_Y = 10'(SCREEN_H - 1);

  // Collision monitor FSM
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } mon_state_e;

endpackage

// File: rtl/hp_counter.sv
// Saturating hit-point register: loads HP_MAX on reset, removes DAMAGE per dec strobe, never wraps below 0.
// Latency: hp updates on the clock edge that samples dec; last_hit/zero are combinational from the register.
// Backpressure: none; dec is a single-cycle strobe accepted unconditionally.
module hp_counter #(
  parameter int HP_MAX = 20,
  parameter int DAMAGE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec,
  output logic [6:0] hp,
  output logic       last_hit,
  output logic       zero
);

  localparam logic [6:0] HP_INIT = 7'(HP_MAX);
  localparam logic [6:0] DMG     = 7'(DAMAGE);

  logic [6:0] hp_d, hp_q;

  // Saturating subtract; clamps at zero instead of wrapping
  always_comb begin
    hp_d = hp_q;
    if (dec) begin
      hp_d = (hp_q > DMG) ? (hp_q - DMG) : 7'd0;
    end
  end

  // Hit-point register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_q <= HP_INIT;
    end else begin
      hp_q <= hp_d;
    end
  end

  assign hp       = hp_q;
  assign last_hit = (hp_q <= DMG);   // the next damage would leave 0
  assign zero     = (hp_q == 7'd0);

endmodule

// File: rtl/collision_monitor.sv
// Heart/bullet collision monitor: latches per-bullet overlaps over a frame, applies damage at end-of-frame, then grants invulnerability frames.
// Latency: collision/hitPulse/hp change one cycle after the end-of-frame pixel; heartVisible is combinational from registered state.
// Backpressure: none; consumes one pixel per clock. Optional heart blink during invulnerability with macro HIT_FLASH_EN.
module collision_monitor
  import undertale_pkg::*;
#(
  parameter int N_BULLETS  = 3,
  parameter int HP_MAX     = 20,
  parameter int DAMAGE     = 4,
  parameter int INV_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           state,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic                 heartSpriteOn,
  input  logic [N_BULLETS-1:0] bulletSpriteOn,
  output logic [N_BULLETS-1:0] collision,
  output logic [6:0]           hp,
  output logic                 hitPulse,
  output logic                 gameOver,
  output logic                 heartVisible
);

  localparam int CNT_W = (INV_FRAMES < 1) ? 1 : $clog2(INV_FRAMES + 1);

  logic                 eof;
  logic                 battle;
  logic [N_BULLETS-1:0] ovl;
  logic [N_BULLETS-1:0] hits;
  logic [N_BULLETS-1:0] flags_d, flags_q;
  logic [N_BULLETS-1:0] collision_d, collision_q;
  logic                 hit_pulse_d, hit_pulse_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  mon_state_e           fsm_d, fsm_q;
  logic                 dmg;
  logic                 hp_last;
  logic                 hp_zero;
  logic                 heart_vis;

  assign eof    = (x == EOF_X) && (y == EOF_Y);
  assign battle = (state == ST_BATTLE);
  assign ovl    = (battle && heartSpriteOn) ? bulletSpriteOn : '0;
  // The EOF pixel's own overlap counts toward this frame's verdict
  assign hits   = flags_q | ovl;

  // Per-frame overlap flags: accumulate during battle, clear after the EOF verdict
  always_comb begin
    flags_d = flags_q;
    if (eof) begin
      flags_d = '0;
    end else if (battle && heartSpriteOn) begin
      flags_d = flags_q | bulletSpriteOn;
    end
  end

  // Monitor FSM: next state, invulnerability counter and damage pulses
  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    collision_d = '0;
    hit_pulse_d = 1'b0;
    dmg         = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (battle) fsm_d = ACTIVE;
      end
      ACTIVE: begin
        if (!battle) begin
          fsm_d = IDLE;
        end else if (eof && (|hits)) begin
          // Any number of bullets in one frame costs DAMAGE once
          dmg         = 1'b1;
          collision_d = hits;
          hit_pulse_d = 1'b1;
          if (hp_last) begin
            fsm_d = DEAD;
          end else begin
            fsm_d = INVULN;
            cnt_d = CNT_W'(INV_FRAMES);
          end
        end
      end
      INVULN: begin
        // Counts frames regardless of game state; overlaps are ignored here
        if (eof) begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d = '0;
            fsm_d = ACTIVE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      DEAD: begin
        fsm_d = DEAD;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // State, flag, counter and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      flags_q     <= '0;
      cnt_q       <= '0;
      collision_q <= '0;
      hit_pulse_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      flags_q     <= flags_d;
      cnt_q       <= cnt_d;
      collision_q <= collision_d;
      hit_pulse_q <= hit_pulse_d;
    end
  end

  hp_counter #(
    .HP_MAX (HP_MAX),
    .DAMAGE (DAMAGE)
  ) u_hp (
    .clk      (clk),
    .rst_n    (rst_n),
    .dec      (dmg),
    .hp       (hp),
    .last_hit (hp_last),
    .zero     (hp_zero)
  );

`ifdef HIT_FLASH_EN
  // Blink: frames elapsed since invulnerability began, in groups of 4, odd groups visible
  always_comb begin
    heart_vis = 1'b1;
    if (fsm_q == INVULN) begin
      heart_vis = (((INV_FRAMES - int'(cnt_q)) / 4) % 2) == 1;
    end
  end
`else
  assign heart_vis = 1'b1;
`endif

  assign collision    = collision_q;
  assign hitPulse     = hit_pulse_q;
  assign gameOver     = hp_zero;
  assign heartVisible = heart_vis;

endmodule
